branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_sat_ctr.sv | 20 ++
 rtl/branch_predictor.sv | 112 +++++++++++
 tb/tb_branch_predictor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encoding, mode selectors
// and the per-entry status record.
package bp_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    localparam int MODE_STATIC  = 0;
    localparam int MODE_BIMODAL = 1;

    // Tag and target widths depend on module parameters, so those fields live
    // in parallel arrays next to this record inside the predictor.
    typedef struct packed {
        logic valid;
        ctr_e ctr;
    } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_e ctr_cur,
    input  logic taken,
    output ctr_e ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr_cur;
        case (ctr_cur)
            STRONG_NT: ctr_nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_nxt = taken ? STRONG_T : WEAK_T;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with optional bimodal counters and a
// saturating mispredict statistic; lookups are purely combinational.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int MODE    = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             update_valid,
    input  logic [XLEN-1:0]  update_pc,
    input  logic             update_taken,
    input  logic [XLEN-1:0]  update_target,
    input  logic             update_mispred,
    input  logic             clear,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam bit BIMODAL = (MODE == MODE_BIMODAL);

    bp_entry_t        entry_q  [ENTRIES];
    bp_entry_t        entry_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    ctr_e             up_ctr_nxt;
    logic             unused_pc_low;

    // Byte offset within a word never affects indexing or tagging.
    assign unused_pc_low = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[XLEN-1:IDX_W+2];

    assign lk_hit = entry_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);
    assign up_hit = entry_q[up_idx].valid && (tag_q[up_idx] == up_tag);

    assign pred_taken  = lookup_valid && lk_hit && BIMODAL && entry_q[lk_idx].ctr[1];
    assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);
    assign mispred_cnt = mispred_cnt_q;

    bp_sat_ctr u_sat_ctr (
        .ctr_cur (entry_q[up_idx].ctr),
        .taken   (update_taken),
        .ctr_nxt (up_ctr_nxt)
    );

    // Clear takes priority over any update arriving in the same cycle.
    always_comb begin
        entry_d  = entry_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_d[i].valid = 1'b0;
            end
        end else if (update_valid && BIMODAL) begin
            if (up_hit) begin
                entry_d[up_idx].ctr = up_ctr_nxt;
                if (update_taken) begin
                    target_d[up_idx] = update_target;
                end
            end else if (update_taken) begin
                entry_d[up_idx].valid = 1'b1;
                entry_d[up_idx].ctr   = WEAK_T;
                tag_d[up_idx]         = up_tag;
                target_d[up_idx]      = update_target;
            end
        end
    end

    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (update_valid && update_mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i]  <= '{valid: 1'b0, ctr: WEAK_NT};
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            mispred_cnt_q <= '0;
        end else begin
            entry_q       <= entry_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: a bimodal predictor and a static one share stimulus and
// are compared against an array-based model of the prediction rules.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispred;
    logic        clear;

    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  mispred_cnt;
    logic        s_pred_taken;
    logic [31:0] s_pred_target;
    logic [3:0]  s_mispred_cnt;

    int tests;
    int failures;

    // Reference model state
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    int          m_cnt;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_mispred(update_mispred), .clear(clear),
        .mispred_cnt(mispred_cnt)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(0), .CNT_W(4)) dut_static (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_mispred(update_mispred), .clear(clear),
        .mispred_cnt(s_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_ctr[i]    = 1;
            m_tag[i]    = 0;
            m_target[i] = 32'h0;
        end
        m_cnt = 0;
    endfunction

    // Applies the effect of the currently driven inputs at the coming clock edge.
    function automatic void modelUpdate();
        int unsigned idx;
        int unsigned tg;
        idx = (update_pc >> 2) & 32'hF;
        tg  = update_pc >> 6;
        if (update_valid && update_mispred && m_cnt < 15) m_cnt++;
        if (clear) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (update_valid) begin
            if (m_valid[idx] && m_tag[idx] == tg) begin
                if (update_taken) begin
                    m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                    m_target[idx] = update_target;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (update_taken) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = tg;
                m_target[idx] = update_target;
                m_ctr[idx]    = 2;
            end
        end
    endfunction

    task automatic checkOutput(input string tag);
        int unsigned idx;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [3:0]  exp_cnt;
        idx = (lookup_pc >> 2) & 32'hF;
        exp_taken  = lookup_valid && m_valid[idx] && (m_tag[idx] == (lookup_pc >> 6)) && (m_ctr[idx] >= 2);
        exp_target = exp_taken ? m_target[idx] : lookup_pc + 32'd4;
        exp_cnt    = 4'(m_cnt);

        tests++;
        assert (pred_taken === exp_taken) else begin
            failures++;
            $error("[TB] FAIL %s pred_taken: observed %0b expected %0b", tag, pred_taken, exp_taken);
        end
        tests++;
        assert (pred_target === exp_target) else begin
            failures++;
            $error("[TB] FAIL %s pred_target: observed %h expected %h", tag, pred_target, exp_target);
        end
        tests++;
        assert (mispred_cnt === exp_cnt) else begin
            failures++;
            $error("[TB] FAIL %s mispred_cnt: observed %h expected %h", tag, mispred_cnt, exp_cnt);
        end
        tests++;
        assert (s_pred_taken === 1'b0) else begin
            failures++;
            $error("[TB] FAIL %s static pred_taken: observed %0b expected 0", tag, s_pred_taken);
        end
        tests++;
        assert (s_pred_target === lookup_pc + 32'd4) else begin
            failures++;
            $error("[TB] FAIL %s static pred_target: observed %h expected %h", tag, s_pred_target, lookup_pc + 32'd4);
        end
        tests++;
        assert (s_mispred_cnt === exp_cnt) else begin
            failures++;
            $error("[TB] FAIL %s static mispred_cnt: observed %h expected %h", tag, s_mispred_cnt, exp_cnt);
        end
    endtask

    // Drive one cycle of inputs, check the combinational view before the edge,
    // then advance the model to match what the edge will commit.
    task automatic applyStimulus(input logic lv, input logic [31:0] lpc,
                                 input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utgt,
                                 input logic um, input logic clr,
                                 input string tag);
        @(negedge clk);
        lookup_valid   = lv;
        lookup_pc      = lpc;
        update_valid   = uv;
        update_pc      = upc;
        update_taken   = ut;
        update_target  = utgt;
        update_mispred = um;
        clear          = clr;
        #1;
        checkOutput(tag);
        modelUpdate();
    endtask

    function automatic logic [31:0] randPc();
        logic [25:0] tg;
        logic [3:0]  ix;
        logic [1:0]  lo;
        case ($urandom_range(0, 3))
            0:       tg = 26'd0;
            1:       tg = 26'd1;
            2:       tg = 26'd4;
            default: tg = '1;
        endcase
        ix = 4'($urandom_range(0, 3));
        lo = 2'($urandom_range(0, 3));
        return {tg, ix, lo};
    endfunction

    task automatic randomBatch(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), randPc(),
                          1'($urandom_range(0, 1)), randPc(),
                          1'($urandom_range(0, 2) != 0), $urandom,
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
                          $sformatf("%s%0d", name, i));
        end
    endtask

    initial begin
        tests          = 0;
        failures       = 0;
        rst_n          = 1'b0;
        lookup_valid   = 1'b1;
        lookup_pc      = 32'h100;
        update_valid   = 1'b0;
        update_pc      = 32'h0;
        update_taken   = 1'b0;
        update_target  = 32'h0;
        update_mispred = 1'b0;
        clear          = 1'b0;
        modelReset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, "lookup_cold");
        applyStimulus(1, 32'h100, 1, 32'h100, 1, 32'h200, 1, 0, "same_cycle_no_bypass");
        applyStimulus(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, "after_alloc");
        applyStimulus(1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 0, "alias_miss");
        applyStimulus(0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, "lookup_invalid");

        for (int i = 0; i < 3; i++)
            applyStimulus(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, $sformatf("sat_up%0d", i));
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 32'h100, 1, 32'h102, 0, 32'h0, 0, 0, $sformatf("sat_down%0d", i));
        applyStimulus(1, 32'h100, 1, 32'h100, 1, 32'h280, 0, 0, "sat_low_held");
        applyStimulus(1, 32'h100, 1, 32'h100, 1, 32'h280, 0, 0, "sat_climb");
        applyStimulus(1, 32'h101, 0, 32'h0,   0, 32'h0,   0, 0, "sat_retarget");

        applyStimulus(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, "wrap_miss");
        applyStimulus(1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,  0, 0, "wrap_hit");

        applyStimulus(1, 32'h100, 1, 32'h300, 1, 32'h900, 1, 1, "clear_with_update");
        applyStimulus(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, "clear_miss_a");
        applyStimulus(1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 0, "clear_miss_b");
        applyStimulus(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, "clear_miss_c");

        for (int i = 0; i < 20; i++)
            applyStimulus(1, 32'h700, 1, 32'h700, 0, 32'h0, 1, 0, $sformatf("mispred%0d", i));
        applyStimulus(1, 32'h700, 0, 32'h0, 0, 32'h0, 0, 0, "mispred_held");

        randomBatch(150, "randA");

        // Asynchronous reset landing with an update pending on the same cycle.
        applyStimulus(1, 32'h500, 1, 32'h500, 1, 32'h600, 0, 0, "pre_rst_alloc");
        applyStimulus(1, 32'h500, 0, 32'h0,   0, 32'h0,   0, 0, "pre_rst_hit");
        @(negedge clk);
        lookup_valid   = 1'b1;
        lookup_pc      = 32'h500;
        update_valid   = 1'b1;
        update_pc      = 32'h800;
        update_taken   = 1'b1;
        update_target  = 32'hA00;
        update_mispred = 1'b1;
        clear          = 1'b0;
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async_a");
        lookup_pc = 32'h800;
        #1;
        checkOutput("rst_async_b");
        @(negedge clk);
        update_valid = 1'b0;
        rst_n        = 1'b1;
        applyStimulus(1, 32'h800, 0, 32'h0, 0, 32'h0, 0, 0, "rst_update_dropped");
        applyStimulus(1, 32'h500, 0, 32'h0, 0, 32'h0, 0, 0, "rst_entry_gone");

        randomBatch(150, "randB");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
